// File: rtl/piso_serializer.sv
// piso_serializer: handshaked WIDTH-bit words in, gap-free serial bit stream out.
// A one-word holding buffer lets the next word load on the same edge the current
// word's last bit retires, so back-to-back words leave with no idle cycles.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int                CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam int                OUT_IDX  = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic last, load, accept;

  // Next-state: handshake, hold buffer refill, shifter load/shift and bit count
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;

    last      = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    load      = hold_full_q && ((state_q == IDLE) || last);
    // Ready never looks at din_valid, so there is no combinational loop upstream.
    din_ready = !hold_full_q || load;
    accept    = din_valid && din_ready;

    // A load empties hold; an accept on the same edge refills it.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end

    if (load) begin
      shreg_d = hold_q;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      // cnt holds at WIDTH-1 when the word ends; only a load restarts it.
      if (last) state_d = IDLE;
      else      cnt_d   = cnt_q + 1'b1;
    end
  end

  // State register with synchronous reset; reset drops shifter and hold contents
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
    end
  end

  // Serial-side outputs decode flops only; ser_out is gated to 0 outside SHIFT
  always_comb begin
    ser_valid   = (state_q == SHIFT);
    ser_out     = ser_valid && shreg_q[OUT_IDX];
    frame_start = ser_valid && (cnt_q == '0);
    busy        = ser_valid || hold_full_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance, a per-instance
// bit scoreboard fed on every handshake, a vector table for single words and
// hand-written sequences for back-to-back, backpressure and reset corners.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din, din_l;
  logic       din_valid, din_valid_l;
  logic       din_ready, ser_out, ser_valid, frame_start, busy;
  logic       din_ready_l, ser_out_l, ser_valid_l, frame_start_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .frame_start(frame_start_l), .busy(busy_l));

  typedef struct { logic b; logic f; } sb_t;
  typedef struct { bit lsb; logic [7:0] din; logic [7:0] exp; } vec_t;

  int          n_chk = 0, n_fail = 0;
  sb_t         q_m[$], q_l[$];
  logic [63:0] cap_m = '0, cap_l = '0;
  int          n_m = 0, n_l = 0, runs_m = 0;
  logic        pv_m = 1'b0;
  bit          done = 1'b0;
  bit          sel_l = 1'b0;
  vec_t        vt[6];

  // Selected-instance view used by the table-driven checks
  logic g_ready, g_sv, g_fs, g_busy;
  assign g_ready = sel_l ? din_ready_l   : din_ready;
  assign g_sv    = sel_l ? ser_valid_l   : ser_valid;
  assign g_fs    = sel_l ? frame_start_l : frame_start;
  assign g_busy  = sel_l ? busy_l        : busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called once per falling edge: compare output bits, then record handshakes
  task automatic mon();
    sb_t e;
    if (ser_valid) begin
      chk("m_bit_expected", 32'(q_m.size() > 0), 1);
      if (q_m.size() > 0) begin
        e = q_m.pop_front();
        chk("m_ser_out", 32'(ser_out), 32'(e.b));
        chk("m_frame_start", 32'(frame_start), 32'(e.f));
      end
      cap_m = {cap_m[62:0], ser_out};
      n_m++;
      if (!pv_m) runs_m++;
    end else begin
      chk("m_idle_ser_out", 32'(ser_out), 0);
      chk("m_idle_frame_start", 32'(frame_start), 0);
    end
    pv_m = ser_valid;
    if (ser_valid_l) begin
      chk("l_bit_expected", 32'(q_l.size() > 0), 1);
      if (q_l.size() > 0) begin
        e = q_l.pop_front();
        chk("l_ser_out", 32'(ser_out_l), 32'(e.b));
        chk("l_frame_start", 32'(frame_start_l), 32'(e.f));
      end
      cap_l = {cap_l[62:0], ser_out_l};
      n_l++;
    end else begin
      chk("l_idle_ser_out", 32'(ser_out_l), 0);
    end
    // The coming edge resets: anything queued or offered now is gone.
    if (rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (din_valid && din_ready)
        for (int i = 0; i < 8; i++) q_m.push_back('{b: din[7-i], f: (i == 0)});
      if (din_valid_l && din_ready_l)
        for (int i = 0; i < 8; i++) q_l.push_back('{b: din_l[i], f: (i == 0)});
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (g_busy && k < 60);
    chk(nm, 32'(g_busy), 0);
  endtask

  task automatic send_one(input vec_t v);
    int n0, k;
    n0    = v.lsb ? n_l : n_m;
    sel_l = v.lsb;
    if (v.lsb) begin din_l = v.din; din_valid_l = 1'b1; end
    else       begin din   = v.din; din_valid   = 1'b1; end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!g_ready && k < 50);
    chk("tbl_ready", 32'(g_ready), 1);
    @(posedge clk); #1;
    din_valid = 1'b0; din_valid_l = 1'b0;
    @(negedge clk);
    chk("tbl_e0_valid", 32'(g_sv), 0);
    chk("tbl_e0_busy", 32'(g_busy), 1);
    chk("tbl_e0_ready", 32'(g_ready), 1);
    @(negedge clk);
    chk("tbl_first_valid", 32'(g_sv), 1);
    chk("tbl_first_frame", 32'(g_fs), 1);
    wait_idle("tbl_idle");
    @(posedge clk); #1;
    chk("tbl_bit_count", 32'((v.lsb ? n_l : n_m) - n0), 8);
    chk("tbl_stream", 32'(v.lsb ? cap_l[7:0] : cap_m[7:0]), 32'(v.exp));
  endtask

  task automatic run();
    int          n0, r0, k, idx;
    int          ak[3];
    logic [7:0]  w[3];
    logic [16:0] hits;
    logic [3:0]  win;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ser_out", 32'(ser_out), 0);
    chk("rst_ser_valid", 32'(ser_valid), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_din_ready", 32'(din_ready), 1);
    chk("rst_l_busy", 32'(busy_l), 0);
    chk("rst_l_din_ready", 32'(din_ready_l), 1);
    repeat (20) begin
      @(negedge clk);
      chk("idle_ser_out", 32'(ser_out), 0);
      chk("idle_ser_valid", 32'(ser_valid), 0);
      chk("idle_din_ready", 32'(din_ready), 1);
    end
    @(posedge clk); #1;

    // Single words; expected stream written first-bit-leftmost.
    vt[0] = '{1'b0, 8'hA5, 8'hA5};
    vt[1] = '{1'b0, 8'h3C, 8'h3C};
    vt[2] = '{1'b0, 8'h81, 8'h81};
    vt[3] = '{1'b1, 8'h0D, 8'hB0};
    vt[4] = '{1'b1, 8'h01, 8'h80};
    vt[5] = '{1'b1, 8'hC4, 8'h23};
    for (int i = 0; i < 6; i++) send_one(vt[i]);
    sel_l = 1'b0;

    // Back-to-back 0A,0A into a 1010 detector.
    n0 = n_m; r0 = runs_m; din = 8'h0A; din_valid = 1'b1; idx = 0; k = 0;
    while (idx < 2 && k < 50) begin
      @(negedge clk); k++;
      if (din_ready) idx++;
      @(posedge clk); #1;
      if (idx == 2) din_valid = 1'b0;
    end
    chk("b2b_accepts", idx, 2);
    wait_idle("b2b_idle");
    @(posedge clk); #1;
    chk("b2b_bits", n_m - n0, 16);
    chk("b2b_stream", 32'(cap_m[15:0]), 32'h0A0A);
    chk("b2b_gapfree", runs_m - r0, 1);
    hits = '0;
    for (int p = 4; p <= 16; p++) begin
      win = {cap_m[19-p], cap_m[18-p], cap_m[17-p], cap_m[16-p]};
      if (win == 4'b1010) hits[p] = 1'b1;
    end
    chk("b2b_detector_hits", 32'(hits), 32'h10100);

    // Backpressure: three words, din_valid held high throughout.
    w[0] = 8'hC3; w[1] = 8'h5A; w[2] = 8'hE7;
    n0 = n_m; r0 = runs_m; din = w[0]; din_valid = 1'b1; idx = 0; k = 0;
    while (idx < 3 && k < 100) begin
      @(negedge clk); k++;
      if (din_ready) begin ak[idx] = k; idx++; end
      @(posedge clk); #1;
      if (idx < 3) din = w[idx];
      else         din_valid = 1'b0;
    end
    chk("bp_accepts", idx, 3);
    chk("bp_w1_gap", ak[1] - ak[0], 1);
    chk("bp_w2_gap", ak[2] - ak[0], 9);
    wait_idle("bp_idle");
    @(posedge clk); #1;
    chk("bp_bits", n_m - n0, 24);
    chk("bp_stream", 32'(cap_m[23:0]), 32'hC35AE7);
    chk("bp_gapfree", runs_m - r0, 1);

    // Reset on the 4th bit of FF with 81 waiting in hold.
    w[0] = 8'hFF; w[1] = 8'h81;
    din = w[0]; din_valid = 1'b1; idx = 0; k = 0;
    while (idx < 2 && k < 50) begin
      @(negedge clk); k++;
      if (din_ready) idx++;
      @(posedge clk); #1;
      if (idx < 2) din = w[idx];
      else         din_valid = 1'b0;
    end
    chk("mid_accepts", idx, 2);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 20);
    chk("mid_first_bit", 32'(frame_start), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = n_m;
    @(negedge clk);
    chk("mid_rst_valid", 32'(ser_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(din_ready), 1);
    repeat (20) @(posedge clk);
    #1 chk("mid_no_bits", n_m - n0, 0);

    // Reset wins over an accept offered in the same cycle.
    n0 = n_m; din = 8'h55; din_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("rstacc_busy", 32'(busy), 0);
    repeat (12) @(posedge clk);
    #1 chk("rstacc_no_bits", n_m - n0, 0);

    chk("sb_m_drained", q_m.size(), 0);
    chk("sb_l_drained", q_l.size(), 0);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_l = '0; din_valid = 1'b0; din_valid_l = 1'b0;
    fork
      begin
        run();
        done = 1'b1;
      end
      begin
        @(posedge clk);
        while (!done) begin
          @(negedge clk);
          mon();
        end
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
